// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: digit width, FSM encoding and
// the signed-overflow rule applied to the final result.
package adder_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla4.sv
// Combinational 4-bit carry-lookahead adder: F = A + B + C0, carry out on C4.
module cla4
    import adder_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               c0,
    output logic [DIGIT_W-1:0] f,
    output logic               c4
);

    logic [DIGIT_W-1:0] g;
    logic [DIGIT_W-1:0] p;
    logic               c1;
    logic               c2;
    logic               c3;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        f  = p ^ {c3, c2, c1, c0};
    end

endmodule

// File: rtl/nibble_add_seq.sv
// Sequential adder that sums two W-bit operands one 4-bit digit per cycle,
// LSB first, through a single shared carry-lookahead digit adder.
module nibble_add_seq
    import adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [DIGIT_W*NIBBLES-1:0]   a,
    input  logic [DIGIT_W*NIBBLES-1:0]   b,
    input  logic                         cin,
    output logic                         busy,
    output logic                         done,
    output logic [DIGIT_W*NIBBLES-1:0]   sum,
    output logic                         cout,
    output logic                         ovf
);

    localparam int unsigned W    = DIGIT_W * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [DIGIT_W-1:0] digit_a;
    logic [DIGIT_W-1:0] digit_b;
    logic [DIGIT_W-1:0] digit_f;
    logic               digit_c4;

    // Digit mux written as an unrolled compare so every part-select is constant.
    always_comb begin
        digit_a = '0;
        digit_b = '0;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (idx_q == IdxW'(i)) begin
                digit_a = a_q[i*DIGIT_W +: DIGIT_W];
                digit_b = b_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    cla4 u_cla4 (
        .a  (digit_a),
        .b  (digit_b),
        .c0 (carry_q),
        .f  (digit_f),
        .c4 (digit_c4)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = StRun;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(NIBBLES); i++) begin
                    if (idx_q == IdxW'(i)) begin
                        sum_d[i*DIGIT_W +: DIGIT_W] = digit_f;
                    end
                end
                carry_d = digit_c4;
                if (idx_q == LastIdx) begin
                    // Top digit is being written now, so its MSB comes straight from the adder.
                    cout_d  = digit_c4;
                    ovf_d   = signed_ovf(a_q[W-1], b_q[W-1], digit_f[DIGIT_W-1]);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq: directed adds push expected results,
// a negedge monitor pops and compares whenever done is high.
module tb_nibble_add_seq;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expected result.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) chk("busy_and_done", 32'(busy & done), 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sum", 32'(sum), 32'(e.sum));
                    chk("cout", 32'(cout), 32'(e.cout));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                end
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or bound expires).
    task automatic wait_done(inout int n);
        while (!done && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          input logic [W-1:0] s, input logic c, input logic o);
        int n;
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        push_exp(s, c, o);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("latency", 32'(n), 32'(NIBBLES + 1));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Start raised mid-RUN must be ignored.
        a     = 16'hBC0A;
        b     = 16'h2B5D;
        cin   = 1'b1;
        start = 1'b1;
        push_exp(16'hE768, 1'b0, 1'b0);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        n++;
        @(negedge clk);
        chk("busy_mid_run", 32'(busy), 32'd1);
        a     = 16'h0001;
        b     = 16'h0001;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        n++;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("latency_ignored_start", 32'(n), 32'(NIBBLES + 1));
        repeat (3) @(negedge clk);
        chk("hold_sum", 32'(sum), 32'hE768);
        chk("hold_cout", 32'(cout), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Reset during the second RUN cycle.
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_done", 32'(done), 32'd0);
        chk("midrun_rst_sum", 32'(sum), 32'd0);
        chk("midrun_rst_cout", 32'(cout), 32'd0);
        chk("midrun_rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        do_add(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

        // Start held through DONE: back-to-back adds.
        a     = 16'h8000;
        b     = 16'h8000;
        cin   = 1'b0;
        start = 1'b1;
        push_exp(16'h0000, 1'b1, 1'b1);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        a = 16'h1111;
        b = 16'h2222;
        push_exp(16'h3333, 1'b0, 1'b0);
        wait_done(n);
        chk("latency_b2b_first", 32'(n), 32'(NIBBLES + 1));
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_drops", 32'(done), 32'd0);
        chk("b2b_busy_rises", 32'(busy), 32'd1);
        wait_done(n);
        chk("latency_b2b_second", 32'(n), 32'(NIBBLES + 1));
        repeat (2) @(negedge clk);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4: number of 4-bit digits per operand; W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to add the operands presented this cycle.
REQ-005 The block SHALL have port a, input, W bits: operand A.
REQ-006 The block SHALL have port b, input, W bits: operand B.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in to digit 0.
REQ-008 The block SHALL have port busy, output, 1 bit: high while digits are being processed.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum, output, W bits: result A+B+cin modulo 2^W.
REQ-011 The block SHALL have port cout, output, 1 bit: carry out of the top digit.
REQ-012 The block SHALL have port ovf, output, 1 bit: signed two's-complement overflow.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 The block SHALL accept start only in IDLE or DONE, and SHALL latch a, b and cin into internal registers on the accepting edge, then enter RUN with digit index 0.
REQ-015 The block SHALL ignore start while in RUN, leaving the operand registers and index untouched.
REQ-016 The block SHALL, on each RUN cycle, drive the 4-bit adder with digit[idx] of the A and B registers plus the carry register, then write adder F into sum[4*idx+3:4*idx] and adder C4 into the carry register.
REQ-017 The block SHALL process digits LSB-first; after the RUN cycle with idx = NIBBLES-1 it SHALL enter DONE.
REQ-018 The block SHALL hold DONE for exactly one cycle, asserting done=1, and then move to IDLE, or back to RUN if start is accepted in that cycle.
REQ-019 The block SHALL give a latency of NIBBLES+1 cycles from the accepting edge to done high, and SHALL support a back-to-back throughput of one add every NIBBLES+1 cycles.
REQ-020 The block SHALL drive busy=1 exactly in RUN; done and busy SHALL never both be high.
REQ-021 The block SHALL drive cout in DONE with the final carry register value.
REQ-022 The block SHALL drive ovf in DONE as (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), using the latched operands.
REQ-023 The block SHALL hold sum, cout and ovf stable from DONE until the next accepted start, and SHALL leave them undefined for the user while busy=1.
REQ-024 The block SHALL wrap the sum modulo 2^W with no saturation.
REQ-025 The block SHALL count the digit index from 0 to NIBBLES-1 and SHALL never wrap it inside RUN.

Reset
REQ-026 The block SHALL, on rst=1 at a clock edge in any state including mid-RUN, go to IDLE and clear index, carry, operand registers, sum, cout, ovf, busy and done to 0.
REQ-027 The block SHALL give rst priority over start in the same cycle.

Structure
REQ-028 The block SHALL take the FSM state encoding (IDLE/RUN/DONE) and the DIGIT_W=4 constant from the shared package adder_pkg.
REQ-029 The block SHALL instantiate exactly one sub-module, the combinational 4-bit carry-lookahead adder cla4 (A, B, C0 -> F, C4), and SHALL add no other arithmetic.

Verification
REQ-030 The bench SHALL cover: a=0x1234, b=0x4321, cin=0 -> after 5 cycles done=1, sum=0x5555, cout=0, ovf=0.
REQ-031 The bench SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; carry ripples through all 4 digits.
REQ-032 The bench SHALL cover: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-033 The bench SHALL cover: a=0xBC0A, b=0x2B5D, cin=1 -> sum=0xE768, cout=0, ovf=0; then a second start given during busy with a=0x0001, b=0x0001 is ignored and the result is unchanged.
REQ-034 The bench SHALL cover: start at 0xFFFF+0xFFFF, rst pulsed on the 2nd RUN cycle -> next cycle IDLE with all outputs 0; a fresh 0x0003+0x0004 then yields 0x0007.
REQ-035 The bench SHALL cover: start held high through the DONE cycle with new operands 0x1111+0x2222 -> done pulses for one cycle, busy rises the next cycle, and the second done shows sum=0x3333.
